mem_port_arbiter: RTL and testbench

- Single-port sequencer/arbiter in front of the unified byte-addressed, big-endian instruction/data memory of the multi-cycle MIPS core.
- Shares the one memory port between the instruction-fetch requester and the load/store requester.
- Drives the memory's MemRead/MemWrite strobes, address and write data, and checks alignment and bounds.
- Returns read data, valid and error to the winning requester through a req/gnt/valid handshake.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module : mem_pkg
// Desc   : Shared constants and address-legality helper for mem_port_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int WORD_BYTES = 4;

  // 33-bit sum so addresses close to 2^32 cannot wrap around into range.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_bytes);
    logic [32:0] w_last;
    w_last = {1'b0, addr} + 33'(WORD_BYTES - 1);
    return (addr[1:0] == 2'b00) && (w_last <= 33'(mem_bytes - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module : mem_port_arbiter_if
// Desc   : Fetch/data requester handshakes plus the single memory port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, if_err,
    output d_gnt, d_valid, d_rdata, d_err,
    output MemRead, MemWrite, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, if_err,
    input  d_gnt, d_valid, d_rdata, d_err,
    input  MemRead, MemWrite, mem_addr, mem_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module : mem_arb_pick
// Desc   : Data-first priority with a starvation override for fetch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic       i_if_req,
  input  wire logic       i_d_req,
  input  wire logic [3:0] i_streak,
  output logic            o_win_if,
  output logic            o_win_d
);

  always_comb begin
    o_win_if = i_if_req && (!i_d_req || (i_streak == 4'(STARVE_LIMIT)));
    o_win_d  = i_d_req && !o_win_if;
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Desc   : Shares one memory port between fetch and load/store requesters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int MEM_BYTES     = 1096,
  parameter int STARVE_LIMIT  = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mem_port_arbiter_if.slave  bus
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_own;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_first;
  logic [3:0]  r_cnt;
  logic [3:0]  r_streak;

  logic        w_win_if;
  logic        w_win_d;
  logic        w_any;
  logic [31:0] w_cap_addr;
  logic        w_legal;
  logic        w_last;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_if_req (bus.if_req),
    .i_d_req  (bus.d_req),
    .i_streak (r_streak),
    .o_win_if (w_win_if),
    .o_win_d  (w_win_d)
  );

  always_comb begin
    w_any      = w_win_if | w_win_d;
    w_cap_addr = w_win_d ? bus.d_addr : bus.if_addr;
    w_legal    = addr_legal(w_cap_addr, MEM_BYTES);
    w_last     = (r_cnt == 4'(ACCESS_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = w_legal ? ACCESS : RESP;
      ACCESS:  if (w_last) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_own    <= OWN_IF;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_first  <= 1'b0;
      r_cnt    <= '0;
      r_streak <= '0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_own   <= w_win_d ? OWN_D : OWN_IF;
            r_we    <= w_win_d & bus.d_we;
            r_addr  <= w_cap_addr;
            r_wdata <= w_win_d ? bus.d_wdata : 32'd0;
            r_rdata <= '0;
            r_err   <= ~w_legal;
            r_cnt   <= '0;
            r_first <= 1'b1;
          end
          // Streak counts data grants that made a waiting fetch lose.
          if (w_win_if) begin
            r_streak <= '0;
          end else if (w_win_d) begin
            if (!bus.if_req)           r_streak <= '0;
            else if (r_streak != 4'hF) r_streak <= r_streak + 4'd1;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last && !r_we) r_rdata <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.if_valid  = 1'b0;
    bus.if_rdata  = '0;
    bus.if_err    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d_rdata   = '0;
    bus.d_err     = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = (r_state != IDLE);

    bus.if_gnt = r_first && (r_own == OWN_IF);
    bus.d_gnt  = r_first && (r_own == OWN_D);

    // Address/data stay put through RESP so they outlive the strobes by a cycle.
    if (r_state == ACCESS || r_state == RESP) begin
      bus.mem_addr  = r_addr;
      bus.mem_wdata = r_wdata;
    end

    if (r_state == ACCESS) begin
      bus.MemRead  = ~r_we;
      bus.MemWrite = r_we;
    end

    if (r_state == RESP) begin
      if (r_own == OWN_IF) begin
        bus.if_valid = 1'b1;
        bus.if_rdata = r_rdata;
        bus.if_err   = r_err;
      end else begin
        bus.d_valid = 1'b1;
        bus.d_rdata = r_rdata;
        bus.d_err   = r_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Desc   : Directed checks of mem_port_arbiter with ACCESS_CYCLES of 1 and 3.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic sel;
  logic started;

  logic        if_req_d;
  logic [31:0] if_addr_d;
  logic        d_req_d;
  logic        d_we_d;
  logic [31:0] d_addr_d;
  logic [31:0] d_wdata_d;

  int n_assert;
  int n_fail;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.ACCESS_CYCLES(1), .MEM_BYTES(1096), .STARVE_LIMIT(4)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a)
  );

  mem_port_arbiter #(.ACCESS_CYCLES(3), .MEM_BYTES(1096), .STARVE_LIMIT(4)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_a.if_req  = !sel && if_req_d;
  assign bus_a.d_req   = !sel && d_req_d;
  assign bus_b.if_req  = sel && if_req_d;
  assign bus_b.d_req   = sel && d_req_d;
  assign bus_a.if_addr = if_addr_d;
  assign bus_b.if_addr = if_addr_d;
  assign bus_a.d_we    = d_we_d;
  assign bus_b.d_we    = d_we_d;
  assign bus_a.d_addr  = d_addr_d;
  assign bus_b.d_addr  = d_addr_d;
  assign bus_a.d_wdata = d_wdata_d;
  assign bus_b.d_wdata = d_wdata_d;

  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[11:2]];
  assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[11:2]];

  always @(posedge clk) begin
    if (bus_a.MemWrite) mem_a[bus_a.mem_addr[11:2]] = bus_a.mem_wdata;
    if (bus_b.MemWrite) mem_b[bus_b.mem_addr[11:2]] = bus_b.mem_wdata;
  end

  logic        o_if_gnt, o_if_valid, o_if_err, o_d_gnt, o_d_valid, o_d_err;
  logic        o_rd, o_wr, o_busy;
  logic [31:0] o_if_rdata, o_d_rdata, o_maddr, o_mwdata;

  assign o_if_gnt   = sel ? bus_b.if_gnt   : bus_a.if_gnt;
  assign o_if_valid = sel ? bus_b.if_valid : bus_a.if_valid;
  assign o_if_err   = sel ? bus_b.if_err   : bus_a.if_err;
  assign o_if_rdata = sel ? bus_b.if_rdata : bus_a.if_rdata;
  assign o_d_gnt    = sel ? bus_b.d_gnt    : bus_a.d_gnt;
  assign o_d_valid  = sel ? bus_b.d_valid  : bus_a.d_valid;
  assign o_d_err    = sel ? bus_b.d_err    : bus_a.d_err;
  assign o_d_rdata  = sel ? bus_b.d_rdata  : bus_a.d_rdata;
  assign o_rd       = sel ? bus_b.MemRead  : bus_a.MemRead;
  assign o_wr       = sel ? bus_b.MemWrite : bus_a.MemWrite;
  assign o_busy     = sel ? bus_b.busy     : bus_a.busy;
  assign o_maddr    = sel ? bus_b.mem_addr : bus_a.mem_addr;
  assign o_mwdata   = sel ? bus_b.mem_wdata : bus_a.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe exclusivity on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (started)
      chk("rd_wr_excl", 32'((bus_a.MemRead & bus_a.MemWrite) | (bus_b.MemRead & bus_b.MemWrite)), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag, input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata_exp, input bit err_exp);
    int ac;
    ac = sel ? 3 : 1;
    if (is_d) begin
      d_req_d = 1'b1; d_we_d = we; d_addr_d = addr; d_wdata_d = wdata;
    end else begin
      if_req_d = 1'b1; if_addr_d = addr;
    end
    step();
    chk({tag, "/gnt"},   32'(is_d ? o_d_gnt : o_if_gnt), 32'd1);
    chk({tag, "/ngnt"},  32'(is_d ? o_if_gnt : o_d_gnt), 32'd0);
    d_req_d  = 1'b0;
    if_req_d = 1'b0;
    if (!err_exp) begin
      for (int c = 0; c < ac; c++) begin
        chk({tag, "/rd"},    32'(o_rd), 32'(!we));
        chk({tag, "/wr"},    32'(o_wr), 32'(we));
        chk({tag, "/maddr"}, o_maddr, addr);
        if (we) chk({tag, "/mwdata"}, o_mwdata, wdata);
        chk({tag, "/early"}, 32'(o_d_valid | o_if_valid), 32'd0);
        step();
      end
    end
    chk({tag, "/valid"},  32'(is_d ? o_d_valid : o_if_valid), 32'd1);
    chk({tag, "/nvalid"}, 32'(is_d ? o_if_valid : o_d_valid), 32'd0);
    chk({tag, "/rdata"},  is_d ? o_d_rdata : o_if_rdata, rdata_exp);
    chk({tag, "/err"},    32'(is_d ? o_d_err : o_if_err), 32'(err_exp));
    chk({tag, "/strb"},   32'(o_rd | o_wr), 32'd0);
    chk({tag, "/hold"},   o_maddr, addr);
    step();
    chk({tag, "/idle"},   32'(o_busy), 32'd0);
  endtask

  initial begin
    int n;
    int exp_streak;
    bit exp_if;
    n_assert = 0; n_fail = 0; started = 1'b0;
    sel = 1'b0; rst = 1'b1;
    if_req_d = 1'b0; if_addr_d = '0;
    d_req_d = 1'b0; d_we_d = 1'b0; d_addr_d = '0; d_wdata_d = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0]   = 32'h8C640064;
    mem_a[25]  = 32'h0000001C;
    mem_a[273] = 32'h1234ABCD;
    mem_b[25]  = 32'h0000001C;

    repeat (3) @(posedge clk);
    #1;
    chk("rst/busy",   32'(o_busy), 32'd0);
    chk("rst/strb",   32'(o_rd | o_wr), 32'd0);
    chk("rst/gnt",    32'(o_if_gnt | o_d_gnt), 32'd0);
    chk("rst/valid",  32'(o_if_valid | o_d_valid), 32'd0);
    chk("rst/maddr",  o_maddr, 32'd0);
    chk("rst/streak", 32'(dut_a.r_streak), 32'd0);
    rst = 1'b0;
    started = 1'b1;
    step();

    xfer("fetch0", 1'b0, 1'b0, 32'd0,   32'd0,         32'h8C640064, 1'b0);
    xfer("load100", 1'b1, 1'b0, 32'd100, 32'd0,        32'h0000001C, 1'b0);
    xfer("st108",  1'b1, 1'b1, 32'd108, 32'h0000001E, 32'd0,        1'b0);
    xfer("ld108",  1'b1, 1'b0, 32'd108, 32'd0,        32'h0000001E, 1'b0);

    xfer("e102",   1'b1, 1'b0, 32'd102, 32'd0,  32'd0, 1'b1);
    xfer("e1093",  1'b1, 1'b0, 32'd1093, 32'd0, 32'd0, 1'b1);
    xfer("e1096",  1'b1, 1'b0, 32'd1096, 32'd0, 32'd0, 1'b1);
    xfer("eFFFC",  1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1);
    xfer("est102", 1'b1, 1'b1, 32'd102, 32'h55, 32'd0, 1'b1);
    xfer("eif2",   1'b0, 1'b0, 32'd2,   32'd0,  32'd0, 1'b1);
    xfer("ok1092", 1'b1, 1'b0, 32'd1092, 32'd0, 32'h1234ABCD, 1'b0);
    chk("est102/mem", mem_a[25], 32'h0000001C);

    // Contention: expect D,D,D,D,I repeating, one grant every 3 cycles.
    if_req_d = 1'b1; if_addr_d = 32'd0;
    d_req_d = 1'b1; d_we_d = 1'b0; d_addr_d = 32'd100;
    exp_streak = 0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (!(o_if_gnt || o_d_gnt) && n < 6) begin
        step();
        n++;
      end
      if (n >= 6) begin
        chk("contend/timeout", 32'd0, 32'd1);
        break;
      end
      exp_if = (k % 5 == 4);
      chk("contend/winner", 32'(o_if_gnt), 32'(exp_if));
      chk("contend/onegnt", 32'(o_if_gnt & o_d_gnt), 32'd0);
      exp_streak = exp_if ? 0 : exp_streak + 1;
      chk("contend/streak", 32'(dut_a.r_streak), 32'(exp_streak));
      if (k > 0) chk("contend/gap", 32'(n), 32'd2);
      step();
    end
    if_req_d = 1'b0;
    d_req_d  = 1'b0;
    repeat (3) step();
    chk("contend/drain", 32'(o_busy), 32'd0);

    // Reset in the second ACCESS cycle on the 3-cycle instance.
    sel = 1'b1;
    d_req_d = 1'b1; d_we_d = 1'b0; d_addr_d = 32'd100;
    step();
    chk("mid/gnt", 32'(o_d_gnt), 32'd1);
    chk("mid/rd1", 32'(o_rd), 32'd1);
    d_req_d = 1'b0;
    step();
    chk("mid/rd2", 32'(o_rd), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid/rd_off", 32'(o_rd), 32'd0);
    chk("mid/busy",   32'(o_busy), 32'd0);
    chk("mid/valid",  32'(o_d_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid/novalid", 32'(o_d_valid | o_busy), 32'd0);
    end
    xfer("post_rst", 1'b1, 1'b0, 32'd100, 32'd0, 32'h0000001C, 1'b0);

    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
